// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade engine.
package led_pkg;

  localparam int unsigned LED_CHANNELS   = 3;
  localparam int unsigned LED_LEVEL_BITS = 13;
  localparam int unsigned LED_RATE_BITS  = 16;
  localparam int unsigned LED_CHAN_W     = 2;

  // What a channel's level does on the coming edge.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_JUMP = 2'd3
  } step_e;

endpackage

// File: rtl/led_fade_channel.sv
// One fade channel: holds level/target/rate/prescale, ramps level one LSB
// per rate period toward target, and flags busy/done.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned LEVEL_BITS = LED_LEVEL_BITS,
  parameter int unsigned RATE_BITS  = LED_RATE_BITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_accept,
  input  logic [LEVEL_BITS-1:0] i_target,
  input  logic [RATE_BITS-1:0]  i_rate,
  output logic [LEVEL_BITS-1:0] o_level,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [LEVEL_BITS-1:0] LVL_ONE  = LEVEL_BITS'(1);
  localparam logic [RATE_BITS-1:0]  RATE_ONE = RATE_BITS'(1);

  logic [LEVEL_BITS-1:0] r_level;
  logic [LEVEL_BITS-1:0] r_target;
  logic [RATE_BITS-1:0]  r_rate;
  logic [RATE_BITS-1:0]  r_prescale;
  logic                  r_armed;
  logic                  r_busy;
  logic                  r_done;

  step_e                 w_step;
  logic [LEVEL_BITS-1:0] w_level_next;
  logic [RATE_BITS-1:0]  w_prescale_next;

  // Decide this cycle's step and the resulting level/prescale.
  always_comb begin
    w_step          = STEP_HOLD;
    w_level_next    = r_level;
    w_prescale_next = r_prescale;
    if (r_level != r_target) begin
      if (r_rate == '0) begin
        w_step = STEP_JUMP;
      end else if (r_prescale == r_rate - RATE_ONE) begin
        w_step = (r_target > r_level) ? STEP_UP : STEP_DOWN;
      end else begin
        w_prescale_next = r_prescale + RATE_ONE;
      end
    end
    case (w_step)
      STEP_UP:   begin w_level_next = r_level + LVL_ONE; w_prescale_next = '0; end
      STEP_DOWN: begin w_level_next = r_level - LVL_ONE; w_prescale_next = '0; end
      STEP_JUMP: w_level_next = r_target;
      default:   w_level_next = r_level;
    endcase
  end

  // Channel state; an accepted command overrides any step in the same cycle.
  // r_armed marks a pending done so a target equal to the present level
  // still produces exactly one done pulse on the following edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_level    <= '0;
      r_target   <= '0;
      r_rate     <= '0;
      r_prescale <= '0;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (i_accept) begin
      r_target   <= i_target;
      r_rate     <= i_rate;
      r_prescale <= '0;
      r_armed    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_level    <= w_level_next;
      r_prescale <= w_prescale_next;
      r_busy     <= (w_level_next != r_target);
      r_done     <= r_armed && (w_level_next == r_target);
      if (r_armed && (w_level_next == r_target)) r_armed <= 1'b0;
    end
  end

  assign o_level = r_level;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade engine top: command handshake and decode, error pulse, shared
// PWM counter and per-channel compare outputs.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS   = LED_CHANNELS,
  parameter int unsigned LEVEL_BITS = LED_LEVEL_BITS,
  parameter int unsigned RATE_BITS  = LED_RATE_BITS
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [LED_CHAN_W-1:0]          cmd_chan,
  input  logic [LEVEL_BITS-1:0]          cmd_target,
  input  logic [RATE_BITS-1:0]           cmd_rate,
  output logic                           cmd_err,
  output logic [CHANNELS*LEVEL_BITS-1:0] level,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS-1:0]            done,
  output logic [CHANNELS-1:0]            pwm
);

  localparam logic [LEVEL_BITS-1:0] LVL_ONE = LEVEL_BITS'(1);

  logic                  r_ready;
  logic                  r_err;
  logic [LEVEL_BITS-1:0] r_pwm_cnt;
  logic [CHANNELS-1:0]   r_pwm;

  logic                  w_accept;
  logic                  w_chan_ok;
  logic [CHANNELS-1:0]   w_sel;

  assign w_accept  = cmd_valid && r_ready;
  assign w_chan_ok = (32'(cmd_chan) < CHANNELS);

  // One-hot channel select for an accepted, in-range command.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_sel[i] = w_accept && (32'(cmd_chan) == i);
    end
  end

  // Ready rises one cycle after reset release; error pulses on bad channel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_accept && !w_chan_ok;
    end
  end

  // Free-running PWM counter and registered compare per channel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pwm_cnt <= '0;
      r_pwm     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + LVL_ONE;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_pwm[i] <= (r_pwm_cnt < level[i*LEVEL_BITS +: LEVEL_BITS]);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    led_fade_channel #(
      .LEVEL_BITS (LEVEL_BITS),
      .RATE_BITS  (RATE_BITS)
    ) u_chan (
      .clk      (clk),
      .resetn   (resetn),
      .i_accept (w_sel[g]),
      .i_target (cmd_target),
      .i_rate   (cmd_rate),
      .o_level  (level[g*LEVEL_BITS +: LEVEL_BITS]),
      .o_busy   (busy[g]),
      .o_done   (done[g])
    );
  end

  assign cmd_ready = r_ready;
  assign cmd_err   = r_err;
  assign pwm       = r_pwm;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: directed scenarios plus random commands, every
// cycle compared against a time-based reference model of the fade engine.
module tb_led_fade_pwm;

  localparam int NCH = 3;
  localparam int LB  = 13;
  localparam int RB  = 16;
  localparam int FULL = 8192;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_chan;
  logic [LB-1:0]     cmd_target;
  logic [RB-1:0]     cmd_rate;
  logic              cmd_err;
  logic [NCH*LB-1:0] level;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    pwm;

  led_fade_pwm #(.CHANNELS(NCH), .LEVEL_BITS(LB), .RATE_BITS(RB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_chan   (cmd_chan),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .cmd_err    (cmd_err),
    .level      (level),
    .busy       (busy),
    .done       (done),
    .pwm        (pwm)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute edge count, next scheduled step time per channel.
  longint cyc = 0;
  int     m_level [NCH];
  int     m_tgt   [NCH];
  int     m_rate  [NCH];
  longint m_next  [NCH];
  bit     m_armed [NCH];
  bit     m_busy  [NCH];
  bit     m_done  [NCH];
  bit     m_pwm   [NCH];
  int     m_cnt = 0;
  bit     m_ready = 0;
  bit     m_err = 0;

  task automatic check_all();
    logic [NCH*LB-1:0] el;
    logic [NCH-1:0] eb, ed, ep;
    for (int i = 0; i < NCH; i++) begin
      el[i*LB +: LB] = LB'(m_level[i]);
      eb[i] = m_busy[i];
      ed[i] = m_done[i];
      ep[i] = m_pwm[i];
    end
    checks++;
    assert (cmd_ready === m_ready) else begin errors++; $error("FAIL ready got=%b exp=%b cyc=%0d", cmd_ready, m_ready, cyc); end
    checks++;
    assert (cmd_err === m_err) else begin errors++; $error("FAIL err got=%b exp=%b cyc=%0d", cmd_err, m_err, cyc); end
    checks++;
    assert (level === el) else begin errors++; $error("FAIL level got=%h exp=%h cyc=%0d", level, el, cyc); end
    checks++;
    assert (busy === eb) else begin errors++; $error("FAIL busy got=%b exp=%b cyc=%0d", busy, eb, cyc); end
    checks++;
    assert (done === ed) else begin errors++; $error("FAIL done got=%b exp=%b cyc=%0d", done, ed, cyc); end
    checks++;
    assert (pwm === ep) else begin errors++; $error("FAIL pwm got=%b exp=%b cyc=%0d", pwm, ep, cyc); end
  endtask

  // Advance one clock edge, update the model from the inputs that were
  // present at the edge, then compare outputs 1 time unit later.
  task automatic tick();
    bit acc, rst_n;
    int ch, tg, rt;
    acc   = (cmd_valid === 1'b1) && m_ready;
    rst_n = (resetn === 1'b1);
    ch = int'(cmd_chan);
    tg = int'(cmd_target);
    rt = int'(cmd_rate);
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_level[i] = 0; m_tgt[i] = 0; m_rate[i] = 0; m_next[i] = 0;
        m_armed[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_pwm[i] = 0;
      end
      m_cnt = 0; m_ready = 0; m_err = 0;
    end else begin
      for (int i = 0; i < NCH; i++) m_pwm[i] = (m_cnt < m_level[i]);
      m_cnt = (m_cnt + 1) % FULL;
      m_err = acc && (ch >= NCH);
      for (int i = 0; i < NCH; i++) begin
        if (acc && ch == i) begin
          m_tgt[i] = tg; m_rate[i] = rt; m_next[i] = cyc + rt;
          m_armed[i] = 1; m_done[i] = 0;
        end else begin
          if (m_level[i] != m_tgt[i]) begin
            if (m_rate[i] == 0) m_level[i] = m_tgt[i];
            else if (cyc == m_next[i]) begin
              m_level[i] += (m_tgt[i] > m_level[i]) ? 1 : -1;
              m_next[i] = cyc + m_rate[i];
            end
          end
          m_done[i] = m_armed[i] && (m_level[i] == m_tgt[i]);
          if (m_done[i]) m_armed[i] = 0;
          m_busy[i] = (m_level[i] != m_tgt[i]);
        end
      end
      m_ready = 1;
    end
    #1;
    check_all();
  endtask

  task automatic send(input int ch, input int tg, input int rt);
    cmd_valid  = 1'b1;
    cmd_chan   = 2'(ch);
    cmd_target = LB'(tg);
    cmd_rate   = RB'(rt);
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    int cnt, dcnt, prev, cur, diff;
    bit hit;
    logic [NCH*LB-1:0] saved;
    for (int i = 0; i < NCH; i++) begin
      m_level[i] = 0; m_tgt[i] = 0; m_rate[i] = 0; m_next[i] = 0;
      m_armed[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_pwm[i] = 0;
    end
    resetn = 1'b0; cmd_valid = 1'b0; cmd_chan = '0; cmd_target = '0; cmd_rate = '0;
    @(negedge clk);
    repeat (3) tick();
    checks++;
    assert (cmd_ready === 1'b0) else begin errors++; $error("FAIL ready_in_reset got=%b exp=0", cmd_ready); end

    // Release: ready high after first edge; pwm idle for a full period.
    resetn = 1'b1;
    tick();
    checks++;
    assert (cmd_ready === 1'b1) else begin errors++; $error("FAIL ready_after_release got=%b exp=1", cmd_ready); end
    cnt = 0;
    for (int j = 0; j < FULL; j++) begin tick(); if (pwm !== '0) cnt++; end
    checks++;
    assert (cnt == 0) else begin errors++; $error("FAIL pwm_idle got=%0d exp=0", cnt); end

    // Ch0: target 4, rate 3 -> one LSB every 3 edges.
    send(0, 4, 3);
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j % 3 == 0) begin
        checks++;
        assert (level[LB-1:0] === LB'(j / 3)) else begin errors++; $error("FAIL ch0_ramp got=%0d exp=%0d", level[LB-1:0], j / 3); end
      end
    end
    checks++;
    assert (done[0] === 1'b1) else begin errors++; $error("FAIL ch0_done got=%b exp=1", done[0]); end
    tick();
    checks++;
    assert (busy[0] === 1'b0 && done[0] === 1'b0) else begin errors++; $error("FAIL ch0_after got=%b%b exp=00", busy[0], done[0]); end

    // Same-level command: done next edge, busy stays low.
    send(0, 4, 5);
    tick();
    checks++;
    assert (done[0] === 1'b1 && busy[0] === 1'b0) else begin errors++; $error("FAIL ch0_same got=%b%b exp=10", done[0], busy[0]); end

    // Ch1: jump to full scale, pwm high 8191 of 8192.
    send(1, FULL - 1, 0);
    tick();
    checks++;
    assert (level[LB +: LB] === LB'(FULL - 1) && done[1] === 1'b1) else begin errors++; $error("FAIL ch1_jump got=%0d/%b exp=8191/1", level[LB +: LB], done[1]); end
    tick();
    cnt = 0;
    for (int j = 0; j < FULL; j++) begin tick(); if (pwm[1] === 1'b1) cnt++; end
    checks++;
    assert (cnt == FULL - 1) else begin errors++; $error("FAIL ch1_duty got=%0d exp=%0d", cnt, FULL - 1); end

    // Ch2: ramp up toward 100, retarget to 10 once level reaches 50.
    send(2, 100, 2);
    dcnt = 0; hit = 0;
    for (int j = 0; j < 400 && !hit; j++) begin
      tick();
      if (done[2] === 1'b1) dcnt++;
      if (m_level[2] == 50) hit = 1;
    end
    checks++;
    assert (hit) else begin errors++; $error("FAIL ch2_reach50 got=%0d exp=50", level[2*LB +: LB]); end
    send(2, 10, 2);
    prev = int'(level[2*LB +: LB]);
    for (int j = 0; j < 200; j++) begin
      tick();
      if (done[2] === 1'b1) dcnt++;
      cur = int'(level[2*LB +: LB]);
      diff = cur - prev;
      checks++;
      assert (diff >= -1 && diff <= 0) else begin errors++; $error("FAIL ch2_descend got=%0d exp=%0d or %0d", cur, prev, prev - 1); end
      prev = cur;
    end
    checks++;
    assert (level[2*LB +: LB] === LB'(10) && dcnt == 1) else begin errors++; $error("FAIL ch2_final got=%0d/%0d exp=10/1", level[2*LB +: LB], dcnt); end

    // Invalid channel: error pulse, levels untouched.
    saved = level;
    send(3, 77, 0);
    checks++;
    assert (cmd_err === 1'b1 && level === saved) else begin errors++; $error("FAIL bad_chan got=%b exp=1", cmd_err); end
    tick();
    checks++;
    assert (cmd_err === 1'b0 && level === saved) else begin errors++; $error("FAIL bad_chan_after got=%b exp=0", cmd_err); end

    // Random commands, including mid-ramp retargets and bad channels.
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 7) == 0) send($urandom_range(0, 3), $urandom_range(0, 60), $urandom_range(0, 4));
      else tick();
    end

    // Reset mid-fade clears everything without a done pulse.
    send(0, 1000, 1);
    repeat (20) tick();
    resetn = 1'b0;
    tick();
    checks++;
    assert (level === '0 && done === '0 && busy === '0 && cmd_ready === 1'b0) else begin errors++; $error("FAIL reset_mid got=%h/%b exp=0/0", level, done); end
    tick();
    resetn = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Multi-channel LED fade engine with an integrated PWM output stage, sitting between the board's command source (host register or sequencer) and the LED pins. Accepts brightness commands (channel, target level, step rate) over a valid/ready handshake and ramps each channel's level one LSB at a time toward its target. Each level drives a free-running compare PWM. Runs entirely in the PLL-derived 25 MHz domain behind the design's reset generator.

## Interface
- CHANNELS, 3, number of LED channels (1..4)
- LEVEL_BITS, 13, brightness/PWM resolution
- RATE_BITS, 16, width of step-rate field (cycles per LSB step)

- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low; clock clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted
- cmd_chan  in  2  target channel index
- cmd_target  in  LEVEL_BITS  target brightness
- cmd_rate  in  RATE_BITS  cycles per one-LSB step; 0 = jump
- cmd_err  out  1  one-cycle pulse: accepted command had cmd_chan >= CHANNELS
- level  out  CHANNELS*LEVEL_BITS  current level per channel, channel 0 in LSBs
- busy  out  CHANNELS  level != target for that channel
- done  out  CHANNELS  one-cycle pulse when channel reaches its target
- pwm  out  CHANNELS  PWM LED drive, active-high

## Operation
- Handshake: transfer on rising edge with cmd_valid && cmd_ready. cmd_ready = 0 while resetn low, 1 from the first cycle after release; never otherwise deasserted.
- Invalid channel: command consumed, no state change, cmd_err pulses one cycle.
- Per channel state: level, target, rate, prescale counter (RATE_BITS).
- On accept: target <= cmd_target, rate <= cmd_rate, prescale <= 0. Current level kept (retarget mid-fade continues from present level, no jump).
- rate == 0: level <= target on next edge.
- rate R > 0, level != target: each cycle, if prescale == R-1 then level steps +1 or -1 toward target and prescale <= 0, else prescale++. No overshoot, no wrap; level stays within 0..2^LEVEL_BITS-1.
- done[i] pulses on the edge level becomes equal to target. Command with target == current level: done pulses at the following edge, busy stays 0.
- Simultaneous command and step on same channel: command wins; the step is discarded, prescale cleared.
- PWM: shared free-running LEVEL_BITS counter pwm_cnt, wraps 2^LEVEL_BITS-1 -> 0. pwm[i] <= (pwm_cnt < level[i]). Level 0 -> always off; max level -> on 2^LEVEL_BITS-1 of 2^LEVEL_BITS cycles.

## Timing
- Reset values: level 0, target 0, rate 0, prescale 0, pwm_cnt 0, pwm 0, busy 0, done 0, cmd_err 0, cmd_ready 0.
- Command accepted at edge k, rate R>0: first step at edge k+R, then every R cycles; full ramp of D LSBs completes at edge k+R*D, done high in cycle after that edge.
- rate 0: level = target and done pulse at edge k+1.
- busy registered: high from edge k+1 until level == target edge.
- pwm lags level by one cycle (registered compare).
- Reset mid-fade: all state cleared at next edge, no done pulse.

## Structure
- Package led_pkg: LEVEL_BITS and RATE_BITS defaults, CHANNELS default, channel-index width constant.
- Sub-module led_fade_channel: one channel's level/target/rate/prescale logic with done/busy; instantiated CHANNELS times via generate. Top holds handshake decode, error pulse, pwm_cnt, PWM comparators.

## Test plan
- Reset release: all outputs 0; cmd_ready high first cycle after resetn=1; pwm stays 0 for 2^13 cycles.
- Ch0 target 4, rate 3 accepted at edge k: level 1,2,3,4 at edges k+3,k+6,k+9,k+12; done[0] pulse at k+12; busy[0] low after.
- Ch1 rate 0 target 8191: level 8191 at k+1, done pulse; pwm[1] high 8191 of 8192 cycles.
- Ch2 ramping up at rate 2 from 0 to 100, retarget to 10 at level 50: level descends 50->10 with no jump, one done pulse only at 10.
- cmd_chan 3 with CHANNELS=3: cmd_err one-cycle pulse, all levels unchanged; resetn low mid-fade clears all levels, no done.
